// File: rtl/memory_encoder.sv
// Packs pairs of 8-bit pixel codes into {earlier, later} 16-bit words and writes one frame to pixel RAM.
// Optional MEMORY_ENCODER_FLUSH_EN adds a FLUSH input that ends the frame early.
//   state   | meaning
//   IDLE    | waiting for START; word counter held at 0
//   FILL_HI | waiting for the earlier pixel of a word
//   FILL_LO | waiting for the later pixel; transfer issues the write next cycle
module memory_encoder #(
    parameter int ADDR_WIDTH  = 14,
    parameter int FRAME_WORDS = 9600
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [7:0]            PIX_CODE,
    input  logic                  PIX_VALID,
    output logic                  PIX_READY,
    output logic [15:0]           MEM_IN,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_WE,
    output logic                  BUSY,
    output logic                  DONE
`ifdef MEMORY_ENCODER_FLUSH_EN
    ,
    input  logic                  FLUSH
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL_HI = 2'd1,
        FILL_LO = 2'd2
    } state_t;

    state_t                state;
    logic [7:0]            hi_byte;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic                  flush_req;
    logic                  pix_xfer;

`ifdef MEMORY_ENCODER_FLUSH_EN
    assign flush_req = FLUSH;
`else
    assign flush_req = 1'b0;
`endif

    assign PIX_READY = (state == FILL_HI) || (state == FILL_LO);
    assign BUSY      = (state != IDLE);
    assign pix_xfer  = PIX_VALID && PIX_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            hi_byte  <= 8'h00;
            word_cnt <= '0;
            MEM_IN   <= 16'h0000;
            MEM_ADDR <= '0;
            MEM_WE   <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            MEM_WE <= 1'b0;
            DONE   <= 1'b0;
            case (state)
                IDLE: begin
                    word_cnt <= '0;
                    if (START) begin
                        state <= FILL_HI;
                    end
                end
                FILL_HI: begin
                    // flush wins over a coincident pixel transfer
                    if (flush_req) begin
                        DONE  <= 1'b1;
                        state <= IDLE;
                    end else if (pix_xfer) begin
                        hi_byte <= PIX_CODE;
                        state   <= FILL_LO;
                    end
                end
                FILL_LO: begin
                    if (flush_req) begin
                        MEM_WE   <= 1'b1;
                        MEM_IN   <= {hi_byte, 8'h00};
                        MEM_ADDR <= word_cnt;
                        DONE     <= 1'b1;
                        state    <= IDLE;
                    end else if (pix_xfer) begin
                        MEM_WE   <= 1'b1;
                        MEM_IN   <= {hi_byte, PIX_CODE};
                        MEM_ADDR <= word_cnt;
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            DONE  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= FILL_HI;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_encoder.sv
// Self-checking bench for memory_encoder: directed steps plus random traffic against a pixel-count model.
module tb_memory_encoder;

    localparam int AW = 4;
    localparam int FW = 4;

    logic          CLK;
    logic          RST_N;
    logic          START;
    logic [7:0]    PIX_CODE;
    logic          PIX_VALID;
    logic          PIX_READY;
    logic [15:0]   MEM_IN;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_WE;
    logic          BUSY;
    logic          DONE;
`ifdef MEMORY_ENCODER_FLUSH_EN
    logic          FLUSH;
`endif

    // single-word frame instance
    logic          b_start;
    logic [7:0]    b_code;
    logic          b_valid;
    logic          b_ready;
    logic [15:0]   b_mem_in;
    logic [0:0]    b_addr;
    logic          b_we;
    logic          b_busy;
    logic          b_done;
`ifdef MEMORY_ENCODER_FLUSH_EN
    logic          b_flush;
`endif

    memory_encoder #(.ADDR_WIDTH(AW), .FRAME_WORDS(FW)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .PIX_CODE(PIX_CODE),
        .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .MEM_IN(MEM_IN),
        .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .BUSY(BUSY), .DONE(DONE)
`ifdef MEMORY_ENCODER_FLUSH_EN
        , .FLUSH(FLUSH)
`endif
    );

    memory_encoder #(.ADDR_WIDTH(1), .FRAME_WORDS(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .START(b_start), .PIX_CODE(b_code),
        .PIX_VALID(b_valid), .PIX_READY(b_ready), .MEM_IN(b_mem_in),
        .MEM_ADDR(b_addr), .MEM_WE(b_we), .BUSY(b_busy), .DONE(b_done)
`ifdef MEMORY_ENCODER_FLUSH_EN
        , .FLUSH(b_flush)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: frame progress is just the number of pixels accepted so far
    bit          m_busy;
    int          m_nacc;
    logic [7:0]  m_hi;
    logic        e_we;
    logic        e_done;
    logic [15:0] e_in;
    logic [AW-1:0] e_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_nacc = 0; m_hi = 8'h00;
        e_we = 0; e_done = 0; e_in = 16'h0000; e_addr = '0;
    endtask

    task automatic check_outputs();
        chk("ready", 32'(PIX_READY), 32'(m_busy));
        chk("busy",  32'(BUSY),      32'(m_busy));
        chk("we",    32'(MEM_WE),    32'(e_we));
        chk("done",  32'(DONE),      32'(e_done));
        chk("data",  32'(MEM_IN),    32'(e_in));
        chk("addr",  32'(MEM_ADDR),  32'(e_addr));
    endtask

    task automatic model_update(input logic st, input logic v, input logic [7:0] c, input logic fl);
        e_we = 0;
        e_done = 0;
        if (!m_busy) begin
            if (st) begin
                m_busy = 1;
                m_nacc = 0;
            end
        end
`ifdef MEMORY_ENCODER_FLUSH_EN
        else if (fl) begin
            if (m_nacc % 2 == 1) begin
                e_we = 1;
                e_in = {m_hi, 8'h00};
                e_addr = AW'(m_nacc / 2);
            end
            e_done = 1;
            m_busy = 0;
        end
`endif
        else if (v) begin
            if (m_nacc % 2 == 0) begin
                m_hi = c;
            end else begin
                e_we = 1;
                e_in = {m_hi, c};
                e_addr = AW'(m_nacc / 2);
                if (m_nacc / 2 == FW - 1) begin
                    e_done = 1;
                    m_busy = 0;
                end
            end
            m_nacc++;
        end
        if (fl === 1'bx) m_hi = m_hi;
    endtask

    // called at posedge+1: check this cycle, drive inputs, advance model, move to next posedge+1
    task automatic step(input logic st, input logic v, input logic [7:0] c, input logic fl);
        check_outputs();
        START = st; PIX_VALID = v; PIX_CODE = c;
`ifdef MEMORY_ENCODER_FLUSH_EN
        FLUSH = fl;
`endif
        model_update(st, v, c, fl);
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [7:0] seq_a [8];
        logic [7:0] c;
        RST_N = 1'b0; START = 0; PIX_VALID = 0; PIX_CODE = 8'h00;
        b_start = 0; b_valid = 0; b_code = 8'h00;
`ifdef MEMORY_ENCODER_FLUSH_EN
        FLUSH = 0; b_flush = 0;
`endif
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", 32'(PIX_READY), 32'h0);
        chk("rst_busy",  32'(BUSY),      32'h0);
        chk("rst_we",    32'(MEM_WE),    32'h0);
        chk("rst_done",  32'(DONE),      32'h0);
        chk("rst_data",  32'(MEM_IN),    32'h0);
        chk("rst_addr",  32'(MEM_ADDR),  32'h0);
        RST_N = 1'b1;

        // A55A, F9FA, then two more words to finish the frame
        seq_a = '{8'hA5, 8'h5A, 8'hF9, 8'hFA, 8'h10, 8'h20, 8'h30, 8'h40};
        step(1, 0, 8'h00, 0);
        foreach (seq_a[i]) step(0, 1, seq_a[i], 0);
        // START in the DONE cycle, then 01..08 back to back
        step(1, 0, 8'h00, 0);
        for (int i = 1; i <= 8; i++) step(0, 1, 8'(i), 0);
        step(0, 0, 8'h00, 0);

        // valid gaps, then START mid-frame
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h11, 0);
        step(0, 0, 8'hEE, 0);
        step(0, 0, 8'hDD, 0);
        step(0, 1, 8'h22, 0);
        step(1, 1, 8'h44, 0);
        step(1, 1, 8'h55, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h60 + i), 0);
        step(0, 0, 8'h00, 0);

        // reset after one accepted pixel of a frame
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h33, 0);
        RST_N = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_ready", 32'(PIX_READY), 32'h0);
        chk("mid_rst_we",    32'(MEM_WE),    32'h0);
        chk("mid_rst_busy",  32'(BUSY),      32'h0);
        chk("mid_rst_data",  32'(MEM_IN),    32'h0);
        START = 0; PIX_VALID = 0;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        step(0, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'hC1, 0);
        step(0, 1, 8'hC2, 0);
        step(0, 0, 8'h00, 0);

`ifdef MEMORY_ENCODER_FLUSH_EN
        step(0, 1, 8'h7E, 0);
        step(0, 1, 8'h99, 1);
        step(0, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            c = 8'($urandom);
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7), c,
                 ($urandom_range(0, 39) == 0));
        end
        check_outputs();

        // single-word frame: two pixels, one write with DONE
        @(negedge CLK);
        b_start = 1;
        @(posedge CLK); #1;
        b_start = 0;
        chk("fw1_ready", 32'(b_ready), 32'h1);
        b_valid = 1; b_code = 8'hC3;
        @(posedge CLK); #1;
        chk("fw1_we_early", 32'(b_we), 32'h0);
        b_code = 8'h3C;
        @(posedge CLK); #1;
        b_valid = 0;
        chk("fw1_we",    32'(b_we),     32'h1);
        chk("fw1_done",  32'(b_done),   32'h1);
        chk("fw1_data",  32'(b_mem_in), 32'hC33C);
        chk("fw1_addr",  32'(b_addr),   32'h0);
        chk("fw1_busy",  32'(b_busy),   32'h0);
        chk("fw1_ready2", 32'(b_ready), 32'h0);
        @(posedge CLK); #1;
        chk("fw1_we_after", 32'(b_we),  32'h0);
        chk("fw1_hold",  32'(b_mem_in), 32'hC33C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_encoder.md
# memory_encoder

Packs a stream of 8-bit pixel colour codes into 16-bit words and writes one full frame into the pixel memory. It is the write-side counterpart of the palette decoder: the word `{first_code, second_code}` it writes is exactly the word the decoder later reads and expands to two 24-bit RGB pixels. It sits between the game's frame renderer (producer) and the pixel RAM write port.

## Interface

Parameters:
- `ADDR_WIDTH`, 14: width of the word address.
- `FRAME_WORDS`, 9600: words per frame (160x120 pixels / 2). Must be ≥ 1 and ≤ 2^ADDR_WIDTH.

Ports:
- `CLK`  in  1  single clock; all logic on its rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `START`  in  1  single-cycle request to begin a frame. Honoured only in IDLE.
- `PIX_CODE`  in  8  pixel colour code.
- `PIX_VALID`  in  1  `PIX_CODE` is valid.
- `PIX_READY`  out  1  block accepts a pixel this cycle.
- `MEM_IN`  out  16  write data. Bits [15:8] hold the earlier pixel; bits [7:0] hold the later pixel.
- `MEM_ADDR`  out  ADDR_WIDTH  write word address.
- `MEM_WE`  out  1  write strobe; one cycle per word.
- `BUSY`  out  1  a frame is in progress.
- `DONE`  out  1  one-cycle pulse that coincides with the final word's `MEM_WE`.
- `FLUSH`  in  1  present only with `MEMORY_ENCODER_FLUSH_EN`.

## Operation

State machine with three states: IDLE, FILL_HI, FILL_LO.

- **IDLE**
  - `START`=1 moves to FILL_HI.
  - The word counter clears to 0.
- **FILL_HI**
  - On a transfer (`PIX_VALID && PIX_READY`), latch `PIX_CODE` into the high byte and move to FILL_LO.
- **FILL_LO**
  - On a transfer, form the word `{hi, PIX_CODE}`.
  - Next cycle: `MEM_WE`=1, `MEM_IN`=word, `MEM_ADDR`=counter. The counter then increments.
  - If this was word `FRAME_WORDS-1`, go to IDLE and pulse `DONE` together with that `MEM_WE`. Otherwise go to FILL_HI.
- `PIX_READY` = (state is FILL_HI or FILL_LO). It is decoded from state only and never depends on `PIX_VALID`.
- `BUSY` = (state ≠ IDLE).
- `MEM_IN`, `MEM_ADDR` and `MEM_WE` are registered. `MEM_IN` and `MEM_ADDR` hold their last written values when `MEM_WE`=0.
- Gaps in `PIX_VALID` stall the current state with no side effects.
- `START` while BUSY is ignored.
- `START` in the cycle the block has just returned to IDLE (the final `MEM_WE`/`DONE` cycle) is honoured.
- The counter runs 0..`FRAME_WORDS-1` and is never compared past that range. There is no wrap-around within a frame.

## Timing

- Reset values: `PIX_READY`=0, `MEM_IN`=16'h0000, `MEM_ADDR`=0, `MEM_WE`=0, `BUSY`=0, `DONE`=0, state IDLE, counter 0.
- `START` sampled at edge t: `PIX_READY`=1 and `BUSY`=1 from t+1.
- Second pixel of a word accepted at edge t: `MEM_WE`=1 during cycle t+1. Latency is 1 cycle.
- Full throughput: one pixel per cycle and one word every 2 cycles, with no bubbles.
- `MEM_WE` of word k overlaps acceptance of the first pixel of word k+1.
- Last pixel accepted at edge t: in cycle t+1 `MEM_WE`=1, `DONE`=1, `PIX_READY`=0, `BUSY`=0.
- `RST_N` low mid-frame: all outputs return to reset values immediately. A partial word is discarded and no write is issued.
- `FRAME_WORDS`=1: two pixels are accepted, then one write with `DONE`.

## Configuration

Macro: `MEMORY_ENCODER_FLUSH_EN`.

- **Defined:**
  - Port `FLUSH` exists and is sampled only while BUSY.
  - In FILL_LO: the next cycle writes `{hi, 8'h00}` at the current counter, pulses `DONE`, and goes to IDLE.
  - In FILL_HI: go to IDLE with `DONE`=1 and no write.
  - A simultaneous pixel transfer in the `FLUSH` cycle is ignored. `PIX_READY` drops in the following cycle.
- **Undefined:** no `FLUSH` port. A frame ends only after `FRAME_WORDS` words or on reset.

## Test plan

- Reset, then `START`, then stream A5,5A,F9,FA with `PIX_VALID` held high: `MEM_WE` pulses give `MEM_IN`=16'hA55A at addr 0, then 16'hF9FA at addr 1, each one cycle after the low byte is accepted.
- `FRAME_WORDS`=4, 8 pixels 01..08 streamed back to back: writes 0102, 0304, 0506, 0708 at addrs 0–3. `DONE` coincides with the addr-3 write, then `BUSY`=0 and `PIX_READY`=0.
- `PIX_VALID` toggled 1,0,0,1 with codes 11,xx,xx,22: exactly one write of 16'h1122. No write during the gaps.
- `START` asserted mid-frame: no restart and the address sequence is unchanged. `START` during the `DONE` cycle: a new frame begins at addr 0.
- `RST_N` pulled low after a single pixel 33 is accepted: no `MEM_WE`, and all outputs return to reset values. A fresh `START` then writes its first word at addr 0.
- (`FLUSH_EN`) Accept 7E, then `FLUSH`: one write of 16'h7E00 at the current addr with `DONE`. `FLUSH` in FILL_HI gives `DONE` with no write.
